mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit; consumes EX/MEM pipeline-register outputs and issues loads/stores on a req/gnt/rvalid data-memory bus.
- Performs byte-lane steering for stores and sign/zero extension for loads.
- Owns the MEM/WB pipeline register.
- Raises StallM to freeze upstream stages while a bus access is outstanding.

---
 rtl/mem_stage_lsu_if.sv | 28 ++
 rtl/mem_stage_lsu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : req/gnt/rvalid data-memory bus between the memory-stage LSU
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage load/store unit. Issues loads/stores on a
//               req/gnt/rvalid bus, steers store byte lanes, extends load
//               data, owns the MEM/WB register and stalls upstream while an
//               access is outstanding. Accesses that wait MAX_WAIT cycles are
//               abandoned with a one-cycle bus_err pulse.
//               Optional macro MISALIGN_TRAP_EN adds a registered 'misalign'
//               pulse and suppresses the bus request for misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
   parameter int MAX_WAIT = 255,
   parameter int CW       = 8
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic [31:0] ALUResultM,
   input  wire logic [31:0] WriteDataM,
   input  wire logic [31:0] PCPlus4M,
   input  wire logic [4:0]  RdM,
   input  wire logic        RegWriteM,
   input  wire logic        MemWriteM,
   input  wire logic [1:0]  ResultSrcM,
   input  wire logic [2:0]  funct3M,
   mem_stage_lsu_if.master  bus,
   output logic             StallM,
   output logic             bus_err,
`ifdef MISALIGN_TRAP_EN
   output logic             misalign,
`endif
   output logic [31:0]      ALUResultW,
   output logic [31:0]      ReadDataW,
   output logic [31:0]      PCPlus4W,
   output logic [4:0]       RdW,
   output logic             RegWriteW,
   output logic [1:0]       ResultSrcW
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bus_err_q, bus_err_d;

   logic [31:0]   alu_w_q, alu_w_d;
   logic [31:0]   rdata_w_q, rdata_w_d;
   logic [31:0]   pc4_w_q, pc4_w_d;
   logic [4:0]    rd_w_q, rd_w_d;
   logic          regwr_w_q, regwr_w_d;
   logic [1:0]    rsrc_w_q, rsrc_w_d;

   logic          is_load, access, mis_acc;
   logic [1:0]    off;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;

   logic          req_c, stall_c, complete, abandon, load_done;

   assign is_load = (ResultSrcM == 2'b01);
   assign access  = MemWriteM | is_load;
   assign off     = ALUResultM[1:0];

`ifdef MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   // Halfword with odd offset or word with any nonzero offset is misaligned.
   assign mis_acc = access &&
                    (((funct3M == 3'b001) || (is_load && funct3M == 3'b101)) && off[0] ||
                     (funct3M == 3'b010) && (off != 2'b00));
   assign misalign_d = (state_q == S_IDLE) && mis_acc;
   assign misalign   = misalign_q;

   // Misalign pulse register.
   always_ff @(posedge clk) begin
      if (!rst) misalign_q <= 1'b0;
      else      misalign_q <= misalign_d;
   end
`else
   assign mis_acc = 1'b0;
`endif

   // Store lane steering: replicate data across lanes, enable only the target bytes.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = WriteDataM;
      case (funct3M)
         3'b000: begin
            st_wdata = {4{WriteDataM[7:0]}};
            st_be    = 4'b0001 << off;
         end
         3'b001: begin
            st_wdata = {2{WriteDataM[15:0]}};
            st_be    = 4'b0011 << {off[1], 1'b0};
         end
         3'b010: st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   // Load extraction: pick byte/halfword by offset, then sign or zero extend.
   always_comb begin
      ld_ext = 32'd0;
      case (off)
         2'd0:    ld_byte = bus.mem_rdata[7:0];
         2'd1:    ld_byte = bus.mem_rdata[15:8];
         2'd2:    ld_byte = bus.mem_rdata[23:16];
         default: ld_byte = bus.mem_rdata[31:24];
      endcase
      ld_half = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (funct3M)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_ext = bus.mem_rdata;
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = 32'd0;
      endcase
   end

   // Access FSM: next state, wait counter, request/stall and completion flags.
   // Timeout takes priority so the counter can never run past MAX_CNT.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bus_err_d = 1'b0;
      req_c     = 1'b0;
      stall_c   = 1'b0;
      complete  = 1'b0;
      abandon   = 1'b0;
      load_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (access && !mis_acc) begin
               req_c = 1'b1;
               if (MemWriteM && bus.mem_gnt) begin
                  complete = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  state_d = bus.mem_gnt ? S_RESP : S_REQ;
               end
            end else begin
               complete = 1'b1;
               abandon  = mis_acc;
            end
         end
         S_REQ: begin
            req_c = 1'b1;
            if (cnt_q == MAX_CNT) begin
               bus_err_d = 1'b1;
               complete  = 1'b1;
               abandon   = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else if (bus.mem_gnt && MemWriteM) begin
               complete = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (bus.mem_gnt) state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (cnt_q == MAX_CNT) begin
               bus_err_d = 1'b1;
               complete  = 1'b1;
               abandon   = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else if (bus.mem_rvalid) begin
               complete  = 1'b1;
               load_done = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Bus outputs; address and data follow the held *M inputs directly.
   assign bus.mem_req   = req_c & rst;
   assign bus.mem_we    = MemWriteM;
   assign bus.mem_addr  = {ALUResultM[31:2], 2'b00};
   assign bus.mem_wdata = st_wdata;
   assign bus.mem_be    = MemWriteM ? st_be : 4'b1111;
   assign StallM        = stall_c & rst;
   assign bus_err       = bus_err_q;

   // MEM/WB next value: capture on completion, bubble while stalled.
   always_comb begin
      alu_w_d   = alu_w_q;
      rdata_w_d = rdata_w_q;
      pc4_w_d   = pc4_w_q;
      rd_w_d    = rd_w_q;
      regwr_w_d = regwr_w_q;
      rsrc_w_d  = rsrc_w_q;
      if (complete) begin
         alu_w_d   = ALUResultM;
         pc4_w_d   = PCPlus4M;
         rd_w_d    = RdM;
         regwr_w_d = RegWriteM & ~abandon;
         rsrc_w_d  = ResultSrcM;
         if (load_done) rdata_w_d = ld_ext;
      end else begin
         rd_w_d    = 5'd0;
         regwr_w_d = 1'b0;
      end
   end

   // FSM state, wait counter and bus error pulse registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_w_q   <= 32'd0;
         rdata_w_q <= 32'd0;
         pc4_w_q   <= 32'd0;
         rd_w_q    <= 5'd0;
         regwr_w_q <= 1'b0;
         rsrc_w_q  <= 2'd0;
      end else begin
         alu_w_q   <= alu_w_d;
         rdata_w_q <= rdata_w_d;
         pc4_w_q   <= pc4_w_d;
         rd_w_q    <= rd_w_d;
         regwr_w_q <= regwr_w_d;
         rsrc_w_q  <= rsrc_w_d;
      end
   end

   assign ALUResultW = alu_w_q;
   assign ReadDataW  = rdata_w_q;
   assign PCPlus4W   = pc4_w_q;
   assign RdW        = rd_w_q;
   assign RegWriteW  = regwr_w_q;
   assign ResultSrcW = rsrc_w_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: directed scenarios
//               plus randomized back-to-back traffic against a behavioural
//               model of lane steering, load extension and stall timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic        StallM, bus_err;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int checks = 0;
   int passed = 0;
   logic [31:0] exp_rdw = 32'd0;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.MAX_WAIT(4), .CW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .funct3M    (funct3M),
      .bus        (bus),
      .StallM     (StallM),
      .bus_err    (bus_err),
`ifdef MISALIGN_TRAP_EN
      .misalign   (misalign),
`endif
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] o);
      case (f3)
         3'd0:    return 4'b0001 << o;
         3'd1:    return 4'b0011 << (2 * (o / 2));
         3'd2:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return {24'd0, d[7:0]} * 32'h01010101;
         3'd1:    return {16'd0, d[15:0]} * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] o,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * o)) & 32'hFF;
      h = (w >> (16 * (o / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'h10000   : h;
         3'd2:    return w;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      ALUResultM = 32'd0;  WriteDataM = 32'd0; PCPlus4M = 32'd0;
      RdM = 5'd0; RegWriteM = 1'b0; MemWriteM = 1'b0;
      ResultSrcM = 2'b00; funct3M = 3'b000;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle();
      rst = 1'b0;
      MemWriteM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40; RegWriteM = 1'b1; RdM = 5'd3;
      tick();
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || StallM !== 1'b0)
         $display("FAIL reset_req_stall: got req=%b stall=%b expected 0 0", bus.mem_req, StallM);
      else passed++;
      checks++;
      if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, bus_err} !== '0)
         $display("FAIL reset_w: got alu=%h rd=%h pc=%h rdw=%h rw=%b rs=%h err=%b expected all 0",
                  ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, bus_err);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_req !== 1'b1)
         $display("FAIL reset_release_req: got %b expected 1", bus.mem_req);
      else passed++;
      set_idle();
      tick();
   endtask

   task automatic test_alu_pass();
      set_idle();
      ResultSrcM = 2'b00; RdM = 5'd5; RegWriteM = 1'b1; ALUResultM = 32'h1234; PCPlus4M = 32'h88;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || StallM !== 1'b0)
         $display("FAIL alu_req_stall: got req=%b stall=%b expected 0 0", bus.mem_req, StallM);
      else passed++;
      tick();
      checks++;
      if (ALUResultW !== 32'h1234 || RdW !== 5'd5 || RegWriteW !== 1'b1 || PCPlus4W !== 32'h88)
         $display("FAIL alu_w: got alu=%h rd=%0d rw=%b pc=%h expected 1234 5 1 88",
                  ALUResultW, RdW, RegWriteW, PCPlus4W);
      else passed++;
   endtask

   task automatic test_store_sb();
      int stalls = 0;
      set_idle();
      MemWriteM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h1003; WriteDataM = 32'h000000AB;
      for (int c = 0; c < 3; c++) begin
         bus.mem_gnt = (c == 2);
         #1;
         if (c == 0) begin
            checks++;
            if (bus.mem_be !== 4'b1000 || bus.mem_wdata !== 32'hABABABAB ||
                bus.mem_addr !== 32'h1000 || bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1)
               $display("FAIL sb_bus: got be=%b wd=%h addr=%h we=%b req=%b expected 1000 abababab 1000 1 1",
                        bus.mem_be, bus.mem_wdata, bus.mem_addr, bus.mem_we, bus.mem_req);
            else passed++;
         end
         if (StallM === 1'b1) stalls++;
         tick();
         bus.mem_gnt = 1'b0;
      end
      checks++;
      if (stalls != 2)
         $display("FAIL sb_stall_cycles: got %0d expected 2", stalls);
      else passed++;
      checks++;
      if (ALUResultW !== 32'h1003 || RegWriteW !== 1'b0)
         $display("FAIL sb_w: got alu=%h rw=%b expected 1003 0", ALUResultW, RegWriteW);
      else passed++;
      set_idle();
   endtask

   task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] expv);
      int stalls = 0;
      set_idle();
      ResultSrcM = 2'b01; funct3M = f3; ALUResultM = 32'h2001; RegWriteM = 1'b1; RdM = 5'd7;
      bus.mem_rdata = 32'h00F08000;
      bus.mem_gnt = 1'b1;
      #1;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_we !== 1'b0)
         $display("FAIL load_req: got req=%b addr=%h we=%b expected 1 2000 0",
                  bus.mem_req, bus.mem_addr, bus.mem_we);
      else passed++;
      if (StallM === 1'b1) stalls++;
      tick();
      bus.mem_gnt = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         bus.mem_rvalid = (c == 3);
         #1;
         if (StallM === 1'b1) stalls++;
         tick();
      end
      bus.mem_rvalid = 1'b0;
      checks++;
      if (stalls != 3)
         $display("FAIL load_stall_cycles: got %0d expected 3", stalls);
      else passed++;
      checks++;
      if (ReadDataW !== expv || RegWriteW !== 1'b1 || RdW !== 5'd7)
         $display("FAIL load_w f3=%0d: got rd=%h rw=%b rdw=%0d expected %h 1 7",
                  f3, ReadDataW, RegWriteW, RdW, expv);
      else passed++;
      exp_rdw = expv;
      set_idle();
   endtask

   task automatic test_timeout();
      int stalls = 0;
      set_idle();
      ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h300; RegWriteM = 1'b1; RdM = 5'd9;
      for (int c = 0; c <= 5; c++) begin
         #1;
         if (StallM === 1'b1) stalls++;
         if (c == 5) begin
            checks++;
            if (StallM !== 1'b0)
               $display("FAIL timeout_release: got stall=%b expected 0", StallM);
            else passed++;
         end
         tick();
      end
      checks++;
      if (stalls != 5)
         $display("FAIL timeout_stall_cycles: got %0d expected 5", stalls);
      else passed++;
      checks++;
      if (bus_err !== 1'b1 || RegWriteW !== 1'b0)
         $display("FAIL timeout_err: got err=%b rw=%b expected 1 0", bus_err, RegWriteW);
      else passed++;
      set_idle();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || StallM !== 1'b0)
         $display("FAIL timeout_idle: got req=%b stall=%b expected 0 0", bus.mem_req, StallM);
      else passed++;
      tick();
      checks++;
      if (bus_err !== 1'b0 || ReadDataW !== exp_rdw)
         $display("FAIL timeout_late_rvalid: got err=%b rd=%h expected 0 %h", bus_err, ReadDataW, exp_rdw);
      else passed++;
      set_idle();
   endtask

   task automatic test_reset_mid_resp();
      set_idle();
      ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h400; RegWriteM = 1'b1; RdM = 5'd4;
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      #1;
      checks++;
      if (StallM !== 1'b1)
         $display("FAIL midresp_wait: got stall=%b expected 1", StallM);
      else passed++;
      rst = 1'b0;
      #1;
      checks++;
      if (StallM !== 1'b0)
         $display("FAIL midresp_reset_stall: got %b expected 0", StallM);
      else passed++;
      tick();
      rst = 1'b1;
      set_idle();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
      #1;
      checks++;
      if (StallM !== 1'b0 || bus.mem_req !== 1'b0)
         $display("FAIL midresp_idle: got stall=%b req=%b expected 0 0", StallM, bus.mem_req);
      else passed++;
      tick();
      checks++;
      if (ReadDataW !== 32'd0 || RegWriteW !== 1'b0)
         $display("FAIL midresp_late_rvalid: got rd=%h rw=%b expected 0 0", ReadDataW, RegWriteW);
      else passed++;
      exp_rdw = 32'd0;
      set_idle();
   endtask

   task automatic test_back_to_back();
      logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [1:0] alu_src [3] = '{2'b00, 2'b10, 2'b11};
      for (int t = 0; t < 60; t++) begin
         int kind, g, r;
         logic [31:0] rdata;
         kind = int'($urandom_range(0, 2));
         g    = int'($urandom_range(0, 2));
         r    = int'($urandom_range(1, 2));
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
         ALUResultM = $urandom; WriteDataM = $urandom; PCPlus4M = $urandom;
         RdM = 5'($urandom); RegWriteM = 1'($urandom);
         MemWriteM = (kind == 1);
         ResultSrcM = (kind == 2) ? 2'b01 : alu_src[$urandom_range(0, 2)];
         funct3M = (kind == 1) ? 3'($urandom_range(0, 3)) : ld_f3[$urandom_range(0, 4)];
`ifdef MISALIGN_TRAP_EN
         ALUResultM[1:0] = 2'b00;
`endif
         rdata = $urandom;
         bus.mem_rdata = rdata;
         if (kind == 0) begin
            #1;
            checks++;
            if (bus.mem_req !== 1'b0 || StallM !== 1'b0)
               $display("FAIL rnd_alu t=%0d: got req=%b stall=%b expected 0 0", t, bus.mem_req, StallM);
            else passed++;
            tick();
         end else begin
            for (int c = 0; c <= g; c++) begin
               bus.mem_gnt = (c == g);
               #1;
               checks++;
               if (bus.mem_req !== 1'b1 || bus.mem_addr !== (ALUResultM & 32'hFFFFFFFC) ||
                   bus.mem_we !== MemWriteM ||
                   (kind == 1 && (bus.mem_be !== exp_be(funct3M, ALUResultM[1:0]) ||
                                  bus.mem_wdata !== exp_wdata(funct3M, WriteDataM))) ||
                   StallM !== ((kind == 2) || (c != g)))
                  $display("FAIL rnd_req t=%0d c=%0d: got req=%b addr=%h be=%b wd=%h stall=%b expected addr=%h be=%b wd=%h",
                           t, c, bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata, StallM,
                           ALUResultM & 32'hFFFFFFFC, exp_be(funct3M, ALUResultM[1:0]),
                           exp_wdata(funct3M, WriteDataM));
               else passed++;
               tick();
               bus.mem_gnt = 1'b0;
               if (!(kind == 1 && c == g)) begin
                  checks++;
                  if (RegWriteW !== 1'b0 || RdW !== 5'd0)
                     $display("FAIL rnd_bubble t=%0d: got rw=%b rd=%0d expected 0 0", t, RegWriteW, RdW);
                  else passed++;
               end
            end
            if (kind == 2) begin
               for (int c = 1; c <= r; c++) begin
                  bus.mem_rvalid = (c == r);
                  #1;
                  checks++;
                  if (bus.mem_req !== 1'b0 || StallM !== (c != r))
                     $display("FAIL rnd_resp t=%0d c=%0d: got req=%b stall=%b expected 0 %b",
                              t, c, bus.mem_req, StallM, c != r);
                  else passed++;
                  tick();
               end
               bus.mem_rvalid = 1'b0;
               exp_rdw = exp_load(funct3M, ALUResultM[1:0], rdata);
            end
         end
         checks++;
         if (ALUResultW !== ALUResultM || PCPlus4W !== PCPlus4M || RdW !== RdM ||
             RegWriteW !== RegWriteM || ResultSrcW !== ResultSrcM || ReadDataW !== exp_rdw)
            $display("FAIL rnd_w t=%0d kind=%0d f3=%0d: got alu=%h pc=%h rd=%0d rw=%b rs=%b data=%h expected %h %h %0d %b %b %h",
                     t, kind, funct3M, ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW, ReadDataW,
                     ALUResultM, PCPlus4M, RdM, RegWriteM, ResultSrcM, exp_rdw);
         else passed++;
      end
      set_idle();
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      test_reset();
      test_alu_pass();
      test_store_sb();
      test_load_byte(3'b000, 32'hFFFFFF80);
      test_load_byte(3'b100, 32'h00000080);
      test_timeout();
      test_reset_mid_resp();
      test_back_to_back();
      tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
